// File: rtl/step_ctrl.sv
// step_ctrl -- single-step / free-run controller for a small core.
//
// The raw push button is synchronized, debounced on clock-divider ticks and
// turned into a one-shot step request on its rising edge. A four-state FSM
// (IDLE, RUN, STEP, HALTED) turns ticks into registered one-cycle core
// clock-enable pulses and keeps a saturating count of pulses issued.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   tick      one-cycle clock-enable pulse from the divider
//   btn_raw   raw asynchronous step button, active high
//   run_mode  1 = free-run, 0 = single-step
//   halt      halt request from the core (level)
//   cpu_en    registered one-cycle core clock-enable pulse
//   state     0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//   btn_db    debounced button level
//   step_cnt  cpu_en pulses since reset, saturating at 255
module step_ctrl #(
  parameter int unsigned DB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_raw,
  input  logic       run_mode,
  input  logic       halt,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       btn_db,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } st_t;

  localparam logic [3:0] DB_LIM = 4'(DB_TICKS);

  st_t        st;
  logic       sync1, sync2;
  logic [3:0] db_cnt;
  logic       btn_db_d;
  logic       step_req;

  assign state = st;

  // Two-flop synchronizer; nothing else looks at btn_raw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the counter only advances on ticks while the synchronized
  // level disagrees with btn_db; any agreement restarts it. The level flips
  // on the tick that brings the count up to DB_TICKS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt   <= 4'd0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (sync2 == btn_db) begin
        db_cnt <= 4'd0;
      end else if (tick) begin
        if (db_cnt + 4'd1 >= DB_LIM) begin
          btn_db <= sync2;
          db_cnt <= 4'd0;
        end else begin
          db_cnt <= db_cnt + 4'd1;
        end
      end
    end
  end

  // One cycle high after btn_db rises. Both flops reset to 0, so reset
  // release cannot fake an edge.
  assign step_req = btn_db & ~btn_db_d;

  // Main FSM. cpu_en is registered, so a pulse appears the cycle after the
  // tick that caused it. Ticks are only acted on in a state we were already
  // in, so a tick coincident with entering RUN/STEP is ignored. Step
  // requests seen outside IDLE simply fall away. The ~cpu_en term keeps the
  // enable from ever lasting two cycles even if ticks arrive back to back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      case (st)
        IDLE: begin
          if (run_mode)      st <= RUN;
          else if (step_req) st <= STEP;
        end
        RUN: begin
          if (halt) begin
            st <= HALTED;
          end else begin
            // A tick in the same cycle as run_mode dropping is still honoured.
            if (tick) cpu_en <= ~cpu_en;
            if (!run_mode) st <= IDLE;
          end
        end
        STEP: begin
          if (halt) begin
            st <= HALTED;
          end else if (tick) begin
            cpu_en <= ~cpu_en;
            st     <= IDLE;
          end
        end
        HALTED: begin
          if (!halt && !run_mode) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Saturating pulse counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= 8'd0;
    end else if (cpu_en && step_cnt != 8'hFF) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DB_TICKS, default 4, is the number of consecutive tick pulses the synchronized button must hold a new level before the debounced level changes; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle clock-enable pulse from the clock-divider stage; the block acts on tick=1 cycles only where stated.
REQ-005 btn_raw  input  1  raw, asynchronous single-step push button, active-high.
REQ-006 run_mode  input  1  1 = free-run, 0 = single-step.
REQ-007 halt  input  1  halt request from the core, level.
REQ-008 cpu_en  output  1  registered one-cycle core clock-enable pulse.
REQ-009 state  output  2  current FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED.
REQ-010 btn_db  output  1  debounced button level.
REQ-011 step_cnt  output  8  count of cpu_en pulses issued since reset.

Function
REQ-012 btn_raw SHALL pass through a two-flop synchronizer before any other use; no other logic samples btn_raw.
REQ-013 Debounce: a 4-bit counter clears on any cycle where the synchronized button equals btn_db; on tick cycles where they differ, it increments.
REQ-014 When the debounce counter reaches DB_TICKS, btn_db SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-015 A step request is a one-cycle internal pulse on the 0->1 transition of btn_db; falling transitions generate nothing.
REQ-016 IDLE: run_mode=1 -> RUN; otherwise a step request -> STEP; otherwise stay.
REQ-017 RUN: halt=1 -> HALTED (highest priority); else run_mode=0 -> IDLE; else stay; cpu_en SHALL be 1 on the cycle after each tick seen in RUN when halt=0.
REQ-018 STEP: halt=1 -> HALTED with no pulse; else on the first tick -> IDLE, and cpu_en SHALL be 1 for exactly the following cycle.
REQ-019 HALTED: cpu_en held 0; exit to IDLE only when halt=0 and run_mode=0 in the same cycle.
REQ-020 cpu_en SHALL never be high for two consecutive cycles and SHALL be 0 outside the cases in REQ-017/018.
REQ-021 step_cnt SHALL increment by 1 on each cycle cpu_en=1 and saturate at 255; no wrap.
REQ-022 Step requests arriving in RUN, STEP or HALTED SHALL be discarded, not queued.
REQ-023 A tick coincident with the state entering RUN or STEP SHALL NOT produce a pulse; only ticks sampled while already in that state count.
REQ-024 run_mode changing to 0 while in RUN with a tick in the same cycle: tick is honoured (one pulse), then IDLE.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, cpu_en=0, btn_db=0, step_cnt=0, synchronizer flops and debounce counter to 0, regardless of clk.
REQ-026 Reset asserted mid-operation (any state, mid-debounce) SHALL abandon all pending activity; after release the block behaves exactly as after power-up.
REQ-027 Release of rst SHALL NOT by itself generate a step request or a cpu_en pulse.

Verification
REQ-028 run_mode=0, btn_raw held 1, tick every 3 cycles, DB_TICKS=4 -> btn_db rises on the 4th tick after sync, state goes IDLE->STEP->IDLE, exactly one cpu_en pulse, step_cnt=1.
REQ-029 btn_raw bouncing 1/0 every 2 cycles for 20 cycles, then stable 0 -> btn_db stays 0, no cpu_en, step_cnt=0.
REQ-030 run_mode=1, 10 ticks, then halt=1 -> 10 cpu_en pulses, each one cycle after its tick, state=3, no further pulses; halt=0 with run_mode=0 -> state=0.
REQ-031 run_mode=1 for 300 ticks -> step_cnt reaches 255 and holds at 255.
REQ-032 rst pulsed low asynchronously mid-cycle while in RUN with step_cnt=7 -> all outputs 0 and state=0 before the next clk edge; pulses resume only after rst=1 and the next tick in RUN.
REQ-033 btn press completed while in RUN, then run_mode=0 -> state=IDLE with no STEP entry and no extra cpu_en.
